// File: rtl/i2s_tx_out.sv
// I2S transmit output stage: rescales 32-bit samples to saturated 16-bit words and
// serialises each as a mono-duplicated I2S frame with locally generated bclk/lrclk.
module i2s_tx_out #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 4,
    parameter int BCLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [IN_WIDTH-1:0] sample_in,
    output logic                ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                overrun,
    output logic                underrun
);
    localparam int WW = IN_WIDTH + SHIFT;
    localparam int FW = 2 * OUT_WIDTH;
    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(FW);

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
    localparam logic [BW-1:0] BIT_HALF = BW'(OUT_WIDTH);

    localparam logic signed [WW-1:0] SAT_MAX = {{(WW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_MIN = {{(WW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q;
    logic [DW-1:0]        div_cnt_q;
    logic                 bclk_q;
    logic                 lrclk_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [BW-1:0]        bit_cnt_d;
    logic [FW-1:0]        shreg_q;
    logic [OUT_WIDTH-1:0] buf_q;
    logic                 buf_full_q;
    logic                 buf_full_d;
    logic                 ready_q;
    logic                 overrun_q;
    logic                 underrun_q;

    logic signed [WW-1:0] wide;
    logic [OUT_WIDTH-1:0] sat_word;
    logic                 div_wrap;
    logic                 fall_ev;
    logic                 load_ev;

    assign div_wrap  = (div_cnt_q == DIV_LAST);
    assign fall_ev   = div_wrap && bclk_q;
    assign bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    // Loading as bit_cnt enters 1 gives the one-bclk I2S data delay after lrclk.
    assign load_ev   = fall_ev && (bit_cnt_q == '0);

    always_comb begin
        wide = {{SHIFT{sample_in[IN_WIDTH-1]}}, sample_in};
        wide = wide <<< SHIFT;
        if (wide > SAT_MAX)
            sat_word = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (wide < SAT_MIN)
            sat_word = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            sat_word = wide[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            lrclk_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_wrap ? '0 : div_cnt_q + 1'b1;
            if (div_wrap)
                bclk_q <= ~bclk_q;
            if (fall_ev) begin
                bit_cnt_q <= bit_cnt_d;
                if (bit_cnt_d == '0)
                    lrclk_q <= 1'b0;
                else if (bit_cnt_d == BIT_HALF)
                    lrclk_q <= 1'b1;
            end
        end
    end

    // A new sample always lands; the load only frees the buffer if nothing arrives.
    always_comb begin
        buf_full_d = buf_full_q;
        if (valid)
            buf_full_d = 1'b1;
        else if (load_ev && buf_full_q)
            buf_full_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            ready_q    <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
            ready_q    <= !buf_full_d;
            overrun_q  <= valid && buf_full_q && !load_ev;
            if (valid)
                buf_q <= sat_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (load_ev) begin
                case (state_q)
                    IDLE: begin
                        if (buf_full_q) begin
                            shreg_q <= {buf_q, buf_q};
                            state_q <= RUN;
                        end else begin
                            shreg_q <= '0;
                        end
                    end
                    RUN: begin
                        if (buf_full_q) begin
                            shreg_q <= {buf_q, buf_q};
                        end else begin
                            shreg_q    <= '0;
                            underrun_q <= 1'b1;
                        end
                    end
                endcase
            end else if (fall_ev) begin
                shreg_q <= {shreg_q[FW-2:0], 1'b0};
            end
        end
    end

    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = shreg_q[FW-1];
    assign ready    = ready_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_out.sv
// Bench for i2s_tx_out: a frame monitor decodes I2S frames into a queue that is
// checked against expected frames pushed as each test drives its samples.
module tb_i2s_tx_out;
    localparam int IN_WIDTH  = 32;
    localparam int OUT_WIDTH = 16;
    localparam int SHIFT     = 4;
    localparam int BCLK_DIV  = 4;
    localparam int FRAME_CLK = 2 * OUT_WIDTH * 2 * BCLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] sample_in = '0;
    logic        ready, bclk, lrclk, sdata, overrun, underrun;

    i2s_tx_out #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT), .BCLK_DIV(BCLK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid), .sample_in(sample_in), .ready(ready),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .overrun(overrun), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  urun;
        logic [7:0]  orun;
    } frame_t;

    frame_t obs_q[$];
    frame_t exp_q[$];
    int     tests_run = 0;
    int     tests_failed = 0;
    int     frames_seen = 0;

    logic [31:0] acc = '0;
    logic        bclk_prev = 1'b0;
    logic        lr_at_rise = 1'b0;
    logic [7:0]  ucnt = '0;
    logic [7:0]  ocnt = '0;

    // Receiver view: sample on bclk rise; a frame closes at the slot where lrclk returns to 0.
    always @(negedge clk) begin
        if (rst) begin
            acc <= '0; bclk_prev <= 1'b0; lr_at_rise <= 1'b0;
            ucnt <= '0; ocnt <= '0; frames_seen <= 0;
        end else begin
            bclk_prev <= bclk;
            if (bclk && !bclk_prev) begin
                acc        <= {acc[30:0], sdata};
                lr_at_rise <= lrclk;
            end
            if (bclk && !bclk_prev && lr_at_rise && !lrclk) begin
                obs_q.push_back({{acc[30:0], sdata}, ucnt + {7'd0, underrun}, ocnt + {7'd0, overrun}});
                frames_seen <= frames_seen + 1;
                ucnt <= '0;
                ocnt <= '0;
            end else begin
                ucnt <= ucnt + {7'd0, underrun};
                ocnt <= ocnt + {7'd0, overrun};
            end
        end
    end

    function automatic logic [15:0] sat_model(input logic [31:0] s);
        longint w;
        w = longint'($signed(s)) * (longint'(1) << SHIFT);
        if (w > 32767) return 16'h7FFF;
        if (w < -32768) return 16'h8000;
        return w[15:0];
    endfunction

    task automatic expect_frame(input logic [15:0] word, input int u, input int o);
        exp_q.push_back({{word, word}, 8'(u), 8'(o)});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; sample_in = '0;
        repeat (3) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int cyc;
        cyc = 0;
        while (frames_seen < n && cyc < (n + 2) * FRAME_CLK) begin
            @(negedge clk);
            cyc++;
        end
        if (frames_seen < n) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_frames: saw %0d frames, need %0d", frames_seen, n);
        end
    endtask

    task automatic send(input logic [31:0] v);
        valid = 1'b1; sample_in = v;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic send_mid(input int k, input logic [31:0] v);
        wait_frames(k);
        repeat (64) @(negedge clk);
        send(v);
    endtask

    task automatic drain();
        frame_t o, e;
        int cyc;
        while (exp_q.size() > 0) begin
            cyc = 0;
            while (obs_q.size() == 0 && cyc < 2 * FRAME_CLK) begin
                @(negedge clk);
                cyc++;
            end
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL frame_timeout: no frame observed, expected data=%h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL frame: got data=%h urun=%0d orun=%0d, expected data=%h urun=%0d orun=%0d",
                             o.data, o.urun, o.orun, e.data, e.urun, e.orun);
                end
            end
        end
    endtask

    task automatic test_reset();
        int bc_r[$];
        int lr_r[$];
        logic bp, lp;
        int ones, ur, nr;
        @(negedge clk);
        rst = 1'b1; valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bclk, lrclk, sdata, ready, overrun, underrun} !== 6'b000100) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 000100", {bclk, lrclk, sdata, ready, overrun, underrun});
        end
        obs_q.delete(); exp_q.delete();
        rst = 1'b0;
        bp = 1'b0; lp = 1'b0; ones = 0; ur = 0; nr = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (bclk && !bp) bc_r.push_back(c);
            if (lrclk && !lp) lr_r.push_back(c);
            bp = bclk; lp = lrclk;
            ones += int'(sdata); ur += int'(underrun); nr += int'(!ready);
        end
        tests_run++;
        if (bc_r.size() < 1 || bc_r[0] != BCLK_DIV) begin
            tests_failed++;
            $display("FAIL bclk_first_rise: got %0d expected %0d", (bc_r.size() > 0) ? bc_r[0] : -1, BCLK_DIV);
        end
        tests_run++;
        if (bc_r.size() < 2 || (bc_r[1] - bc_r[0]) != 2 * BCLK_DIV) begin
            tests_failed++;
            $display("FAIL bclk_period: got %0d expected %0d", (bc_r.size() > 1) ? bc_r[1] - bc_r[0] : -1, 2 * BCLK_DIV);
        end
        tests_run++;
        if (lr_r.size() < 2 || (lr_r[1] - lr_r[0]) != FRAME_CLK) begin
            tests_failed++;
            $display("FAIL lrclk_period: got %0d expected %0d", (lr_r.size() > 1) ? lr_r[1] - lr_r[0] : -1, FRAME_CLK);
        end
        tests_run++;
        if (ones != 0 || ur != 0 || nr != 0) begin
            tests_failed++;
            $display("FAIL idle_quiet: sdata_ones=%0d underruns=%0d ready_low=%0d expected 0 0 0", ones, ur, nr);
        end
        expect_frame(16'h0000, 0, 0);
        expect_frame(16'h0000, 0, 0);
        drain();
    endtask

    task automatic test_single();
        apply_reset();
        expect_frame(16'h0000, 0, 0);
        send_mid(0, 32'h0000_0100);
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_after_accept: got %b expected 0", ready);
        end
        expect_frame(16'h1000, 0, 0);
        expect_frame(16'h0000, 1, 0);
        drain();
    endtask

    task automatic test_saturation();
        apply_reset();
        expect_frame(16'h0000, 0, 0);
        send_mid(0, 32'h0000_1000);
        expect_frame(16'h7FFF, 0, 0);
        send_mid(1, 32'hFFFF_FFFF);
        expect_frame(16'hFFF0, 0, 0);
        send_mid(2, -32'sd5000);
        expect_frame(16'h8000, 0, 0);
        expect_frame(16'h0000, 1, 0);
        drain();
    endtask

    task automatic test_random_words();
        logic [31:0] v;
        apply_reset();
        expect_frame(16'h0000, 0, 0);
        for (int k = 0; k < 4; k++) begin
            v = $urandom;
            v = 32'($signed(v) >>> $urandom_range(8, 24));
            send_mid(k, v);
            expect_frame(sat_model(v), 0, 0);
        end
        expect_frame(16'h0000, 1, 0);
        drain();
    endtask

    task automatic test_overrun();
        apply_reset();
        repeat (40) @(negedge clk);
        send(32'h0000_0010);
        repeat (9) @(negedge clk);
        send(32'h0000_0020);
        expect_frame(16'h0000, 0, 1);
        expect_frame(16'h0200, 0, 0);
        expect_frame(16'h0000, 1, 0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic lp, fell;
        int cyc;
        apply_reset();
        expect_frame(16'h0000, 0, 0);
        send_mid(0, 32'h0000_0123);
        lp = lrclk; fell = 1'b0; cyc = 0;
        while (!fell && cyc < 2 * FRAME_CLK) begin
            @(negedge clk);
            fell = lp && !lrclk;
            lp = lrclk;
            cyc++;
        end
        tests_run++;
        if (!fell) begin
            tests_failed++;
            $display("FAIL lrclk_fall_timeout: got no lrclk fall expected one within %0d clk", 2 * FRAME_CLK);
        end
        cyc = 0;
        while (!bclk && cyc < 4 * BCLK_DIV) begin
            @(negedge clk);
            cyc++;
        end
        repeat (BCLK_DIV - 1) @(negedge clk);
        send(-32'sd100);
        expect_frame(16'h1230, 0, 0);
        expect_frame(16'hF9C0, 0, 0);
        expect_frame(16'h0000, 1, 0);
        drain();
    endtask

    task automatic test_reset_midframe();
        int cyc;
        apply_reset();
        send_mid(0, 32'h0000_0555);
        wait_frames(1);
        repeat (40) @(negedge clk);
        send(32'h0000_0077);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bclk, lrclk, sdata, ready, overrun, underrun} !== 6'b000100) begin
            tests_failed++;
            $display("FAIL midframe_reset_outputs: got %b expected 000100", {bclk, lrclk, sdata, ready, overrun, underrun});
        end
        repeat (3) @(negedge clk);
        obs_q.delete(); exp_q.delete();
        rst = 1'b0;
        cyc = 0;
        while (!bclk && cyc < 4 * BCLK_DIV) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc != BCLK_DIV) begin
            tests_failed++;
            $display("FAIL bclk_restart: got first rise after %0d clk expected %0d", cyc, BCLK_DIV);
        end
        expect_frame(16'h0000, 0, 0);
        expect_frame(16'h0000, 0, 0);
        drain();
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: got %b expected 1", ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_random_words();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 2000000 time units");
        $fatal(1, "watchdog");
    end

endmodule
